// File: rtl/beam_scan_controller.sv
// -----------------------------------------------------------------------------
// beam_scan_controller
//
// Raster sequencer for the beamformer. It sweeps the focus point (p_x, p_y)
// over a square grid in y-major / x-minor order. For each point it holds the
// coordinates while the delay generator settles, then pulses the beamformer
// and waits for its energy result. It keeps the arg-max over the whole scan.
//
// Optional feature (compile-time macro BEAM_SCAN_TIMEOUT_EN):
//   A WAIT watchdog is added. When it expires, the current point is given
//   energy 0, and the sticky o_timeout output is raised.
// -----------------------------------------------------------------------------
module beam_scan_controller #(
    parameter int GRID_MIN    = -64,
    parameter int GRID_MAX    = 64,
    parameter int STEP        = 16,
    parameter int SETTLE_CYC  = 2,
    parameter int ENERGY_W    = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_abort,
    output logic signed [7:0]   o_p_x,
    output logic signed [7:0]   o_p_y,
    output logic                o_bf_start,
    input  logic                i_bf_done,
    input  logic [ENERGY_W-1:0] i_bf_energy,
    output logic                o_busy,
    output logic [7:0]          o_point_idx,
    output logic                o_done,
    output logic                o_best_valid,
    output logic signed [7:0]   o_best_x,
    output logic signed [7:0]   o_best_y,
    output logic [ENERGY_W-1:0] o_best_energy
`ifdef BEAM_SCAN_TIMEOUT_EN
    ,
    output logic                o_timeout
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Coordinates are handled at 9 bits so the end-of-axis compare is exact.
    localparam logic signed [8:0] GMIN9 = 9'(GRID_MIN);
    localparam logic signed [8:0] GMAX9 = 9'(GRID_MAX);
    localparam logic signed [8:0] STEP9 = 9'(STEP);
    localparam logic signed [7:0] GMIN8 = GMIN9[7:0];

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);
    localparam logic [SCW-1:0] SETTLE_ONE  = SCW'(1);
    localparam logic [SCW-1:0] SETTLE_ZERO = SCW'(0);

`ifdef BEAM_SCAN_TIMEOUT_EN
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);
    localparam logic [WDW-1:0] WD_ZERO = WDW'(0);
    logic [WDW-1:0] wd_cnt_r;
`endif

    state_t              state_r;
    logic [SCW-1:0]      settle_cnt_r;
    logic [ENERGY_W-1:0] energy_r;

    logic signed [8:0]   x_ext_s;
    logic signed [8:0]   y_ext_s;
    logic signed [8:0]   x_inc_s;
    logic signed [8:0]   y_inc_s;
    logic                x_at_end_s;
    logic                y_at_end_s;

    // Next raster position. If a step would leave the 8-bit range, it is treated as the end of the axis.
    always_comb begin
        x_ext_s    = {o_p_x[7], o_p_x};
        y_ext_s    = {o_p_y[7], o_p_y};
        x_inc_s    = x_ext_s + STEP9;
        y_inc_s    = y_ext_s + STEP9;
        x_at_end_s = (x_ext_s == GMAX9) || (x_inc_s[8] != x_inc_s[7]);
        y_at_end_s = (y_ext_s == GMAX9) || (y_inc_s[8] != y_inc_s[7]);
    end

    // Scan sequencer: state, raster position, arg-max tracking and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= ST_IDLE;
            settle_cnt_r  <= SETTLE_ZERO;
            energy_r      <= {ENERGY_W{1'b0}};
            o_p_x         <= 8'sd0;
            o_p_y         <= 8'sd0;
            o_bf_start    <= 1'b0;
            o_busy        <= 1'b0;
            o_point_idx   <= 8'd0;
            o_done        <= 1'b0;
            o_best_valid  <= 1'b0;
            o_best_x      <= 8'sd0;
            o_best_y      <= 8'sd0;
            o_best_energy <= {ENERGY_W{1'b0}};
`ifdef BEAM_SCAN_TIMEOUT_EN
            wd_cnt_r      <= WD_ZERO;
            o_timeout     <= 1'b0;
`endif
        end else if ((state_r != ST_IDLE) && i_abort) begin
            // Abort beats everything else. Coordinates and partial best are kept.
            state_r    <= ST_IDLE;
            o_busy     <= 1'b0;
            o_bf_start <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_bf_start <= 1'b0;
            o_done     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        o_p_x         <= GMIN8;
                        o_p_y         <= GMIN8;
                        o_point_idx   <= 8'd0;
                        o_best_valid  <= 1'b0;
                        o_best_energy <= {ENERGY_W{1'b0}};
                        o_best_x      <= GMIN8;
                        o_best_y      <= GMIN8;
                        o_busy        <= 1'b1;
                        settle_cnt_r  <= SETTLE_ZERO;
`ifdef BEAM_SCAN_TIMEOUT_EN
                        o_timeout     <= 1'b0;
`endif
                        state_r       <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        state_r <= ST_FIRE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SETTLE_ONE;
                    end
                end
                ST_FIRE: begin
                    o_bf_start <= 1'b1;
`ifdef BEAM_SCAN_TIMEOUT_EN
                    wd_cnt_r   <= WD_ZERO;
`endif
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_bf_done) begin
                        energy_r <= i_bf_energy;
                        state_r  <= ST_UPDATE;
`ifdef BEAM_SCAN_TIMEOUT_EN
                    end else if (wd_cnt_r == WD_LAST) begin
                        energy_r  <= {ENERGY_W{1'b0}};
                        o_timeout <= 1'b1;
                        state_r   <= ST_UPDATE;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
`endif
                    end
                end
                ST_UPDATE: begin
                    // Strictly greater, so ties keep the earlier point.
                    if ((o_point_idx == 8'd0) || (energy_r > o_best_energy)) begin
                        o_best_x      <= o_p_x;
                        o_best_y      <= o_p_y;
                        o_best_energy <= energy_r;
                    end
                    o_point_idx <= o_point_idx + 8'd1;
                    if (x_at_end_s && y_at_end_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        if (x_at_end_s) begin
                            o_p_x <= GMIN8;
                            o_p_y <= y_inc_s[7:0];
                        end else begin
                            o_p_x <= x_inc_s[7:0];
                        end
                        settle_cnt_r <= SETTLE_ZERO;
                        state_r      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    o_done       <= 1'b1;
                    o_best_valid <= 1'b1;
                    o_busy       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/beam_scan_controller.md
Name: beam_scan_controller

Overview:
- Sequencer that sweeps the beamforming focus point (p_x, p_y) over a square raster grid and drives the per-mic delay generator and the delay-and-sum energy datapath.
- For each point it presents the coordinates, waits for the delays to settle, fires the beamformer, collects the energy result, and tracks the arg-max.
- Sits between the top-level control FSM and the delta generator / beamformer pair. On completion it reports the loudest source location.

Parameters:
- GRID_MIN, -64: first coordinate on each axis (signed, fits 8 bits).
- GRID_MAX, 64: last coordinate on each axis (inclusive). Must equal GRID_MIN + k*STEP.
- STEP, 16: raster increment on each axis (positive). Defaults give 9x9 = 81 points.
- SETTLE_CYC, 2: cycles coordinates are held before firing (at least 1).
- ENERGY_W, 32: width of the energy result.
- TIMEOUT_CYC, 1023: watchdog limit. Used only with the optional feature.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  pulse: begin scan (honoured only in IDLE)
- i_abort  in  1  level/pulse: cancel scan
- o_p_x  out  8 signed  focus x to delta generator
- o_p_y  out  8 signed  focus y to delta generator
- o_bf_start  out  1  one-cycle pulse: beamformer evaluate current point
- i_bf_done  in  1  beamformer result valid
- i_bf_energy  in  ENERGY_W  unsigned energy of current point
- o_busy  out  1  scan in progress
- o_point_idx  out  8  raster index of current point (y-major, x-minor, from 0)
- o_done  out  1  one-cycle pulse: scan completed normally
- o_best_valid  out  1  best_* registers hold a complete-scan result
- o_best_x  out  8 signed  x of maximum-energy point
- o_best_y  out  8 signed  y of maximum-energy point
- o_best_energy  out  ENERGY_W  maximum energy

Behaviour:
- Clock is i_clk. Reset is i_rst, synchronous and active-high.
- Reset values: all outputs 0, state IDLE.
- States: IDLE, SETTLE, FIRE, WAIT, UPDATE, DONE.
- IDLE:
  - On i_start, load o_p_x = o_p_y = GRID_MIN and o_point_idx = 0.
  - Clear o_best_valid and o_best_energy; set o_best_x/o_best_y = GRID_MIN.
  - Go to SETTLE. o_busy = 1 from the next cycle.
- SETTLE: hold coordinates for exactly SETTLE_CYC cycles, then go to FIRE.
- FIRE: assert o_bf_start for one cycle, then go to WAIT.
- WAIT: remain until i_bf_done = 1. Capture i_bf_energy, then go to UPDATE.
  - i_bf_done in any other state is ignored, including the FIRE cycle.
- UPDATE (1 cycle):
  - If o_point_idx == 0, or captured energy > o_best_energy (strictly greater), load best_* with the current point. Ties keep the earlier point.
  - Advance the raster: x += STEP. If x was GRID_MAX, set x = GRID_MIN and y += STEP.
  - o_point_idx increments.
  - After the last point (x = y = GRID_MAX): go to DONE. Otherwise go to SETTLE.
- DONE (1 cycle): o_done = 1, o_best_valid = 1, o_busy = 0 next cycle, then return to IDLE.
- Coordinate arithmetic is done at 9 bits and checked so no 8-bit wrap occurs. The parameters guarantee the range.
- Per-point latency is SETTLE_CYC + 1 + wait + 1 cycles.
- i_abort in any non-IDLE state:
  - Return to IDLE next cycle, o_busy = 0, no o_done, o_best_valid stays 0.
  - Partial best_* retained; o_p_x/o_p_y hold.
  - Abort wins over a simultaneous i_bf_done or last-point UPDATE.
- i_start while busy: ignored. i_start and i_abort together in IDLE: abort wins, stay IDLE.
- i_rst mid-scan: all state and outputs return to reset values on that edge.
- o_best_valid stays 1 until the next accepted i_start.

Optional Feature:
- Macro: BEAM_SCAN_TIMEOUT_EN.
- With it defined:
  - A watchdog counts cycles in WAIT. Reaching TIMEOUT_CYC without i_bf_done forces UPDATE with energy = 0.
  - Sticky output o_timeout (1 bit, reset 0, cleared on accepted i_start) is set.
- Without it: WAIT waits indefinitely, and the o_timeout port and counter do not exist.

Test Plan:
- Full scan, model returns energy = 1000 only at (16,-32), else 5, done 3 cycles after o_bf_start -> 81 o_bf_start pulses, raster order matches, o_done once, best = (16,-32,1000), o_best_valid = 1.
- Tie: energy 700 at idx 10 and idx 50, else 1 -> best_x/y match idx 10 ((-64+1*16, -64+1*16) = (-48,-48)), energy 700.
- Settle timing: SETTLE_CYC = 2 -> o_bf_start occurs exactly 3 cycles after the coordinates change; i_bf_done held high during FIRE is not captured.
- Abort at idx 40 during WAIT coincident with i_bf_done -> IDLE next cycle, o_busy = 0, no o_done, o_best_valid = 0; a new i_start restarts at (-64,-64), idx 0.
- i_start pulsed at idx 5 and i_rst asserted at idx 20 -> start ignored; after reset all outputs 0 and state IDLE.
- With BEAM_SCAN_TIMEOUT_EN, TIMEOUT_CYC = 15, no i_bf_done at idx 3 -> after 15 WAIT cycles the point gets energy 0, o_timeout = 1, and the scan completes with 81 points.
